sqrt_req_arbiter: RTL and testbench

- Shares one combinational 16-bit integer square-root datapath between NUM_REQ requesters.
- Arbitrates requests round-robin and registers the winning operand onto the datapath input.
- Waits a programmable settle time (multicycle path), then captures root and remainder and presents a tagged result on a valid/ready response channel.
- Also checks the datapath result and flags inconsistent results.

---
 rtl/sqrt_req_arbiter_if.sv | 29 ++
 rtl/sqrt_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_sqrt_req_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_req_arbiter_if.sv
// Request/response channels between requesters, result consumer and the
// shared square-root arbiter.
interface sqrt_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [7:0]            rsp_root;
    logic [8:0]            rsp_rem;
    logic                  rsp_exact;
    logic                  rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_root,
        input  rsp_rem, rsp_exact, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_root,
        output rsp_rem, rsp_exact, rsp_err
    );
endinterface

// File: rtl/sqrt_req_arbiter.sv
// Round-robin arbiter sharing one multicycle combinational 16-bit sqrt
// datapath; checks the returned root and tags the result with the winner.
module sqrt_req_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sqrt_req_arbiter_if.slave   bus,
    output logic [15:0]         sq_n,
    input  logic [7:0]          sq_root,
    output logic                busy
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       operand_sel;
    logic              found;
    logic              accept;
    logic              capture;

    logic [15:0]       sq;
    logic [15:0]       diff;
    logic              err_c;
    logic [8:0]        rem_c;
    logic              exact_c;

    logic [7:0]        root_q;
    logic [8:0]        rem_q;
    logic              exact_q;
    logic              err_q;

    // Lowest valid index at or above ptr wins; otherwise lowest valid overall.
    always_comb begin
        found  = |bus.req_valid;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                winner = ID_W'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k] && (k >= int'(ptr))) begin
                winner = ID_W'(k);
            end
        end
    end

    always_comb begin
        operand_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(winner) == k) begin
                operand_sel = bus.req_data[16*k +: 16];
            end
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    accept  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready[k] = accept && (int'(winner) == k);
        end
    end

    // A root is wrong if it overshoots or if root+1 would still fit.
    always_comb begin
        sq      = {8'd0, sq_root} * {8'd0, sq_root};
        diff    = sq_n - sq;
        err_c   = (sq > sq_n) | (diff > {7'd0, sq_root, 1'b0});
        rem_c   = err_c ? 9'd0 : diff[8:0];
        exact_c = ~err_c & (rem_c == 9'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            cnt     <= '0;
            sq_n    <= '0;
            id_q    <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                sq_n <= operand_sel;
                id_q <= winner;
                ptr  <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                cnt  <= CNT_W'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                root_q  <= sq_root;
                rem_q   <= rem_c;
                exact_q <= exact_c;
                err_q   <= err_c;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_root  = root_q;
    assign bus.rsp_rem   = rem_q;
    assign bus.rsp_exact = exact_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Directed and randomized bench for sqrt_req_arbiter with an ideal or
// deliberately faulty sqrt datapath model.
module tb_sqrt_req_arbiter;

    localparam int N = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sq_n;
    logic [7:0]  sq_root;
    logic        busy;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'd0;
    logic [15:0] d [N];

    int   total = 0;
    int   passed = 0;
    int   mptr = 0;
    time  last_acc = 0;

    sqrt_req_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    sqrt_req_arbiter #(
        .NUM_REQ(N),
        .ID_W(2),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .sq_n(sq_n),
        .sq_root(sq_root),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(int n);
        int r = 0;
        for (int i = 0; i < 256; i++) begin
            if (i * i <= n) r = i;
        end
        return r;
    endfunction

    assign sq_root = force_en ? force_val : 8'(isqrt(int'(sq_n)));

    function automatic int model_winner(logic [N-1:0] v, int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic drive(logic [N-1:0] v);
        bus.req_valid = v;
        for (int k = 0; k < N; k++) bus.req_data[16*k +: 16] = d[k];
    endtask

    task automatic scramble();
        for (int k = 0; k < N; k++) d[k] = 16'($urandom);
        drive(N'($urandom));
    endtask

    task automatic txn(int hold, bit chk_gap);
        int w, n, r, sqv, rem, k;
        bit err, exact;
        #1;
        w = model_winner(bus.req_valid, mptr);
        chk("grant", 32'(bus.req_ready), 32'(1 << w));
        n = int'(d[w]);
        r = force_en ? int'(force_val) : isqrt(n);
        @(posedge clk);
        if (chk_gap) chk("accept_gap", 32'($time - last_acc), (S + 2) * 10);
        last_acc = $time;
        mptr = (w + 1) % N;
        @(negedge clk);
        scramble();
        #1;
        chk("settle_ready", 32'(bus.req_ready), 0);
        chk("settle_busy", 32'(busy), 1);
        chk("settle_sq_n", 32'(sq_n), 32'(n));
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, S);
        sqv   = r * r;
        err   = (sqv > n) || ((n - sqv) > 2 * r);
        rem   = err ? 0 : n - sqv;
        exact = !err && (rem == 0);
        chk("rsp_id", 32'(bus.rsp_id), 32'(w));
        chk("rsp_root", 32'(bus.rsp_root), 32'(r));
        chk("rsp_rem", 32'(bus.rsp_rem), 32'(rem));
        chk("rsp_exact", 32'(bus.rsp_exact), 32'(exact));
        chk("rsp_err", 32'(bus.rsp_err), 32'(err));
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            scramble();
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid), 1);
            chk("stall_ready", 32'(bus.req_ready), 0);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_sq_n", 32'(sq_n), 32'(n));
            chk("stall_root", 32'(bus.rsp_root), 32'(r));
            chk("stall_rem", 32'(bus.rsp_rem), 32'(rem));
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("done_valid", 32'(bus.rsp_valid), 0);
        chk("done_busy", 32'(busy), 0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) d[k] = '0;
        drive('0);
        #12;
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sq_n", 32'(sq_n), 0);
        chk("rst_root", 32'(bus.rsp_root), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single request from requester 2
        @(negedge clk);
        d[2] = 16'd144;
        drive(4'b0100);
        txn(0, 0);

        // boundary operands
        d[0] = 16'd0;     drive(4'b0001); txn(0, 0);
        d[1] = 16'd1;     drive(4'b0010); txn(0, 0);
        d[3] = 16'd200;   drive(4'b1000); txn(0, 0);
        d[0] = 16'd65535; drive(4'b0001); txn(0, 0);

        // all requesters contending: round-robin and back-to-back spacing
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) d[k] = 16'($urandom);
            drive(4'b1111);
            txn(0, i > 0);
        end

        // consumer stall
        for (int k = 0; k < N; k++) d[k] = 16'($urandom);
        drive(4'b1111);
        txn(5, 0);

        // faulty datapath roots
        force_en = 1'b1;
        force_val = 8'd13;
        d[1] = 16'd144; drive(4'b0010); txn(0, 0);
        force_val = 8'd11;
        d[1] = 16'd144; drive(4'b0010); txn(0, 0);
        force_en = 1'b0;

        // no requests: nothing granted, pointer holds
        drive('0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.req_ready), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < N; k++) d[k] = 16'($urandom);
            force_en  = ($urandom_range(0, 3) == 0);
            force_val = 8'($urandom);
            drive(N'($urandom_range(1, (1 << N) - 1)));
            txn($urandom_range(0, 3), 0);
        end
        force_en = 1'b0;

        // asynchronous reset during SETTLE
        d[2] = 16'd1000;
        drive(4'b0100);
        #1;
        @(posedge clk);
        @(negedge clk);
        drive('0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(bus.rsp_valid), 0);
        chk("arst_sq_n", 32'(sq_n), 0);
        chk("arst_root", 32'(bus.rsp_root), 0);
        chk("arst_id", 32'(bus.rsp_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mptr = 0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.rsp_valid), 0);
        end
        for (int k = 0; k < N; k++) d[k] = 16'($urandom);
        drive(4'b1111);
        txn(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
